// File: rtl/addsub_seq_param_pkg.sv
// Shared arithmetic definitions for the multi-cycle add/subtract unit:
// FSM state encoding, operation select constants and chunk sizing helpers.
package addsub_seq_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int calc_idx_w(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/addsub_seq_param_chunk.sv
// Combinational CHUNK-bit adder slice; also reports the carry into its MSB
// so the final slice can derive signed overflow.
module addsub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] s,
    output logic             c_out,
    output logic             c_msb
);

    logic [CHUNK:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};
        s     = total[CHUNK-1:0];
        c_out = total[CHUNK];
        // Sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out directly.
        c_msb = total[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];
    end

endmodule

// File: rtl/addsub_seq_param.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock
// through one reused slice adder, with accumulate mode and valid/ready.
module addsub_seq_param
    import addsub_seq_param_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sel,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             over_flow
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = calc_idx_w(NCHUNK);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    state_t state_reg, state_next;

    logic [IDX_W-1:0] idx_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             acc_en_reg;
    logic             c_out_reg;
    logic             over_flow_reg;

    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_co;
    logic             chunk_cmsb;
    logic [WIDTH-1:0] res_merged;
    logic             last_chunk;

    assign a_slice    = op_a_reg[idx_reg*CHUNK +: CHUNK];
    assign b_slice    = op_b_reg[idx_reg*CHUNK +: CHUNK];
    assign last_chunk = (idx_reg == LAST_IDX);

    addsub_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a     (a_slice),
        .b     (b_slice),
        .c_in  (carry_reg),
        .s     (chunk_s),
        .c_out (chunk_co),
        .c_msb (chunk_cmsb)
    );

    // Working result with the current slice merged in; on the last slice this
    // is the complete result copied to the visible output register.
    always_comb begin
        res_merged = res_reg;
        res_merged[idx_reg*CHUNK +: CHUNK] = chunk_s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                if (last_chunk) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_reg       <= '0;
            op_a_reg      <= '0;
            op_b_reg      <= '0;
            res_reg       <= '0;
            acc_reg       <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            acc_en_reg    <= 1'b0;
            c_out_reg     <= 1'b0;
            over_flow_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (acc_clr) begin
                        acc_reg <= '0;
                    end
                    if (in_valid) begin
                        // A clear issued with the accept also zeroes this operand.
                        op_a_reg   <= acc_en ? (acc_clr ? '0 : acc_reg) : a;
                        op_b_reg   <= (sel == SEL_SUB) ? ~b : b;
                        carry_reg  <= (sel == SEL_SUB) ? ~c_in : c_in;
                        acc_en_reg <= acc_en;
                        idx_reg    <= '0;
                    end
                end
                ST_CALC: begin
                    res_reg   <= res_merged;
                    carry_reg <= chunk_co;
                    idx_reg   <= idx_reg + 1'b1;
                    if (last_chunk) begin
                        sum_reg       <= res_merged;
                        c_out_reg     <= chunk_co;
                        over_flow_reg <= chunk_co ^ chunk_cmsb;
                    end
                end
                ST_DONE: begin
                    if (acc_clr) begin
                        acc_reg <= '0;
                    end else if (out_ready && acc_en_reg) begin
                        acc_reg <= sum_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum       = sum_reg;
    assign c_out     = c_out_reg;
    assign over_flow = over_flow_reg;

endmodule

// File: tb/tb_addsub_seq_param.sv
// Directed self-checking bench for addsub_seq_param in three configurations:
// 8/4 (add/sub vectors), 32/8 (backpressure, mode changes), 8/1 (accumulate, reset).
module tb_addsub_seq_param;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // WIDTH=8, CHUNK=4
    logic       x4_in_valid = 0, x4_in_ready, x4_c_in = 0, x4_sel = 0;
    logic       x4_acc_en = 0, x4_acc_clr = 0, x4_out_valid, x4_out_ready = 0;
    logic [7:0] x4_a = 0, x4_b = 0, x4_sum;
    logic       x4_c_out, x4_ovf;

    // WIDTH=32, CHUNK=8
    logic        w32_in_valid = 0, w32_in_ready, w32_c_in = 0, w32_sel = 0;
    logic        w32_acc_en = 0, w32_acc_clr = 0, w32_out_valid, w32_out_ready = 0;
    logic [31:0] w32_a = 0, w32_b = 0, w32_sum;
    logic        w32_c_out, w32_ovf;

    // WIDTH=8, CHUNK=1
    logic       s1_in_valid = 0, s1_in_ready, s1_c_in = 0, s1_sel = 0;
    logic       s1_acc_en = 0, s1_acc_clr = 0, s1_out_valid, s1_out_ready = 0;
    logic [7:0] s1_a = 0, s1_b = 0, s1_sum;
    logic       s1_c_out, s1_ovf;

    addsub_seq_param #(.WIDTH(8), .CHUNK(4)) dut_x4 (
        .clk(clk), .rst_n(rst_n), .in_valid(x4_in_valid), .in_ready(x4_in_ready),
        .a(x4_a), .b(x4_b), .c_in(x4_c_in), .sel(x4_sel), .acc_en(x4_acc_en),
        .acc_clr(x4_acc_clr), .out_valid(x4_out_valid), .out_ready(x4_out_ready),
        .sum(x4_sum), .c_out(x4_c_out), .over_flow(x4_ovf)
    );

    addsub_seq_param #(.WIDTH(32), .CHUNK(8)) dut_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(w32_in_valid), .in_ready(w32_in_ready),
        .a(w32_a), .b(w32_b), .c_in(w32_c_in), .sel(w32_sel), .acc_en(w32_acc_en),
        .acc_clr(w32_acc_clr), .out_valid(w32_out_valid), .out_ready(w32_out_ready),
        .sum(w32_sum), .c_out(w32_c_out), .over_flow(w32_ovf)
    );

    addsub_seq_param #(.WIDTH(8), .CHUNK(1)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(s1_in_valid), .in_ready(s1_in_ready),
        .a(s1_a), .b(s1_b), .c_in(s1_c_in), .sel(s1_sel), .acc_en(s1_acc_en),
        .acc_clr(s1_acc_clr), .out_valid(s1_out_valid), .out_ready(s1_out_ready),
        .sum(s1_sum), .c_out(s1_c_out), .over_flow(s1_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one 8/4 operation to completion; lat = cycles from accept to out_valid.
    task automatic run_x4(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sel, output logic [7:0] s, output logic co,
                          output logic ov, output int lat);
        for (int i = 0; i < 20 && !x4_in_ready; i++) tick();
        x4_a = a; x4_b = b; x4_c_in = cin; x4_sel = sel; x4_in_valid = 1;
        tick();
        x4_in_valid = 0;
        lat = 0;
        while (!x4_out_valid && lat < 40) begin
            tick();
            lat++;
        end
        s = x4_sum; co = x4_c_out; ov = x4_ovf;
        x4_out_ready = 1;
        tick();
        x4_out_ready = 0;
    endtask

    task automatic run_s1(input logic [7:0] a, input logic [7:0] b, input logic sel,
                          input logic acc_en, input logic acc_clr,
                          output logic [7:0] s, output logic co, output int lat);
        for (int i = 0; i < 20 && !s1_in_ready; i++) tick();
        s1_a = a; s1_b = b; s1_c_in = 0; s1_sel = sel;
        s1_acc_en = acc_en; s1_acc_clr = acc_clr; s1_in_valid = 1;
        tick();
        s1_in_valid = 0; s1_acc_clr = 0;
        lat = 0;
        while (!s1_out_valid && lat < 40) begin
            tick();
            lat++;
        end
        s = s1_sum; co = s1_c_out;
        s1_out_ready = 1;
        tick();
        s1_out_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick();
        tick();
        total++;
        if (x4_in_ready !== 1'b1 || x4_out_valid !== 1'b0 || x4_sum !== 8'h00 ||
            x4_c_out !== 1'b0 || x4_ovf !== 1'b0) begin
            $display("FAIL reset_x4 got rdy=%b vld=%b sum=%h co=%b ov=%b want 1 0 00 0 0",
                     x4_in_ready, x4_out_valid, x4_sum, x4_c_out, x4_ovf);
            bad++;
        end
        total++;
        if (w32_in_ready !== 1'b1 || w32_out_valid !== 1'b0 || w32_sum !== 32'h0) begin
            $display("FAIL reset_w32 got rdy=%b vld=%b sum=%h want 1 0 0",
                     w32_in_ready, w32_out_valid, w32_sum);
            bad++;
        end
        rst_n = 1;
        tick();
        $display("reset checked");
    endtask

    task automatic test_addsub_x4();
        logic [7:0] va [4] = '{8'h55, 8'hBB, 8'h11, 8'hFF};
        logic [7:0] vb [4] = '{8'h44, 8'h44, 8'h55, 8'h55};
        logic [7:0] add_s [4] = '{8'h99, 8'hFF, 8'h66, 8'h54};
        logic       add_c [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       add_v [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] sub_s [4] = '{8'h11, 8'h77, 8'hBC, 8'hAA};
        logic       sub_c [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       sub_v [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] s;
        logic co, ov;
        int lat;
        for (int op = 0; op < 2; op++) begin
            for (int i = 0; i < 4; i++) begin
                logic [7:0] es;
                logic ec, ev;
                es = (op == 0) ? add_s[i] : sub_s[i];
                ec = (op == 0) ? add_c[i] : sub_c[i];
                ev = (op == 0) ? add_v[i] : sub_v[i];
                run_x4(va[i], vb[i], 1'b0, op[0], s, co, ov, lat);
                $display("x4 %s %h,%h -> sum=%h c=%b v=%b lat=%0d",
                         (op == 0) ? "add" : "sub", va[i], vb[i], s, co, ov, lat);
                total++;
                if (s !== es || co !== ec || ov !== ev) begin
                    $display("FAIL x4_result op=%0d i=%0d got %h/%b/%b want %h/%b/%b",
                             op, i, s, co, ov, es, ec, ev);
                    bad++;
                end
                total++;
                if (lat !== 2) begin
                    $display("FAIL x4_latency op=%0d i=%0d got %0d want 2", op, i, lat);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        w32_a = 32'hFFFF_FFFF; w32_b = 32'h0; w32_c_in = 1; w32_sel = 0; w32_in_valid = 1;
        tick();
        w32_in_valid = 0;
        total++;
        if (w32_in_ready !== 1'b0) begin
            $display("FAIL w32_busy_ready got %b want 0", w32_in_ready);
            bad++;
        end
        lat = 0;
        while (!w32_out_valid && lat < 40) begin
            tick();
            lat++;
        end
        total++;
        if (lat !== 4) begin
            $display("FAIL w32_latency got %0d want 4", lat);
            bad++;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (w32_out_valid !== 1'b1 || w32_sum !== 32'h0 || w32_c_out !== 1'b1 ||
                w32_ovf !== 1'b0 || w32_in_ready !== 1'b0) begin
                $display("FAIL w32_hold cyc=%0d got vld=%b sum=%h co=%b ov=%b rdy=%b want 1 0 1 0 0",
                         i, w32_out_valid, w32_sum, w32_c_out, w32_ovf, w32_in_ready);
                bad++;
            end
            tick();
        end
        w32_out_ready = 1;
        tick();
        w32_out_ready = 0;
        total++;
        if (w32_out_valid !== 1'b0 || w32_in_ready !== 1'b1) begin
            $display("FAIL w32_release got vld=%b rdy=%b want 0 1", w32_out_valid, w32_in_ready);
            bad++;
        end
        $display("w32 ffffffff+0+1 held 5 cycles, lat=%0d", lat);
    endtask

    task automatic test_mode_change();
        logic [31:0] va [2] = '{32'h1234_5678, 32'h8000_0000};
        logic [31:0] vb [2] = '{32'h1111_1111, 32'h0000_0001};
        logic        vs [2] = '{1'b0, 1'b1};
        logic [31:0] es [2] = '{32'h2345_6789, 32'h7FFF_FFFF};
        logic        ec [2] = '{1'b0, 1'b1};
        logic        ev [2] = '{1'b0, 1'b1};
        for (int i = 0; i < 2; i++) begin
            int lat;
            w32_a = va[i]; w32_b = vb[i]; w32_sel = vs[i]; w32_c_in = 0; w32_in_valid = 1;
            tick();
            w32_in_valid = 0;
            lat = 0;
            while (!w32_out_valid && lat < 40) begin
                w32_a = $urandom; w32_b = $urandom; w32_sel = ~w32_sel; w32_c_in = ~w32_c_in;
                tick();
                lat++;
            end
            w32_a = $urandom; w32_b = $urandom; w32_sel = ~w32_sel;
            tick();
            total++;
            if (w32_sum !== es[i] || w32_c_out !== ec[i] || w32_ovf !== ev[i]) begin
                $display("FAIL w32_mode_change i=%0d got %h/%b/%b want %h/%b/%b",
                         i, w32_sum, w32_c_out, w32_ovf, es[i], ec[i], ev[i]);
                bad++;
            end
            $display("w32 toggled-inputs op %0d -> sum=%h c=%b v=%b", i, w32_sum, w32_c_out, w32_ovf);
            w32_out_ready = 1;
            tick();
            w32_out_ready = 0;
        end
    endtask

    task automatic test_accumulate();
        logic [7:0] vb [4] = '{8'h10, 8'h20, 8'h30, 8'h70};
        logic       vs [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [7:0] es [4] = '{8'h10, 8'h30, 8'h60, 8'hF0};
        logic       ec [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] s;
        logic co;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_s1(8'hA5, vb[i], vs[i], 1'b1, (i == 0), s, co, lat);
            $display("s1 acc %s %h -> sum=%h c=%b lat=%0d", vs[i] ? "sub" : "add", vb[i], s, co, lat);
            total++;
            if (s !== es[i] || co !== ec[i]) begin
                $display("FAIL s1_acc i=%0d got %h/%b want %h/%b", i, s, co, es[i], ec[i]);
                bad++;
            end
            total++;
            if (lat !== 8) begin
                $display("FAIL s1_latency i=%0d got %0d want 8", i, lat);
                bad++;
            end
        end
        s1_acc_en = 0;
    endtask

    task automatic test_reset_mid_op();
        logic [7:0] s;
        logic co;
        int lat;
        s1_a = 8'h12; s1_b = 8'h34; s1_sel = 0; s1_acc_en = 0; s1_in_valid = 1;
        tick();
        s1_in_valid = 0;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        total++;
        if (s1_out_valid !== 1'b0 || s1_in_ready !== 1'b1 || s1_sum !== 8'h00 ||
            s1_c_out !== 1'b0 || s1_ovf !== 1'b0) begin
            $display("FAIL midreset_state got vld=%b rdy=%b sum=%h co=%b ov=%b want 0 1 00 0 0",
                     s1_out_valid, s1_in_ready, s1_sum, s1_c_out, s1_ovf);
            bad++;
        end
        for (int i = 0; i < 10; i++) tick();
        total++;
        if (s1_out_valid !== 1'b0) begin
            $display("FAIL midreset_abort got vld=%b want 0", s1_out_valid);
            bad++;
        end
        run_s1(8'h77, 8'h00, 1'b0, 1'b1, 1'b0, s, co, lat);
        total++;
        if (s !== 8'h00) begin
            $display("FAIL midreset_acc got %h want 00", s);
            bad++;
        end
        run_s1(8'h01, 8'h01, 1'b0, 1'b0, 1'b0, s, co, lat);
        $display("s1 after reset 01+01 -> sum=%h lat=%0d", s, lat);
        total++;
        if (s !== 8'h02 || co !== 1'b0 || lat !== 8) begin
            $display("FAIL midreset_next got %h/%b lat=%0d want 02/0 lat=8", s, co, lat);
            bad++;
        end
    endtask

    initial begin
        test_reset();
        test_addsub_x4();
        test_backpressure();
        test_mode_change();
        test_accumulate();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/addsub_seq_param.md
Name: addsub_seq_param

Overview:
- Parametrised, multi-cycle successor to the 8-bit behavioural full adder.
- Adds or subtracts WIDTH-bit operands CHUNK bits per clock using a registered ripple carry.
- Supports an accumulate mode and valid/ready handshakes on input and output.
- Used as the shared arithmetic unit in datapaths where area matters more than latency.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of CHUNK, WIDTH >= 2.
- CHUNK, 8, bits processed per clock; 1 gives bit-serial operation, CHUNK=WIDTH gives a single-cycle compute.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  operand A; ignored when acc_en=1.
- b  input  WIDTH  operand B.
- c_in  input  1  carry-in for add; borrow-in for sub.
- sel  input  1  0 = add, 1 = subtract.
- acc_en  input  1  use the internal accumulator in place of a.
- acc_clr  input  1  clear the accumulator.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- c_out  output  1  carry-out; for subtract, 1 means no borrow.
- over_flow  output  1  two's-complement signed overflow.

Behaviour:
- Only clk is used; rst_n is sampled synchronously, active-low.
- Reset state: IDLE; in_ready=1; out_valid=0; sum=0; c_out=0; over_flow=0; accumulator=0; chunk index=0.
- NCHUNK = WIDTH/CHUNK.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept on an edge where in_valid=1.
  - On accept, latch opA = (acc_en ? acc : a).
  - Latch opB = (sel ? ~b : b).
  - Initial carry = (sel ? ~c_in : c_in).
  - Latch acc_en; go to CALC with index=0.
- CALC:
  - in_ready=0.
  - Each edge adds CHUNK slice[index] of opA and opB plus the carry register.
  - Writes that sum slice, updates the carry register, increments index.
  - On the edge that processes index NCHUNK-1, go to DONE.
  - Capture c_out = final carry.
  - Capture over_flow = carry into the MSB XOR carry out of the MSB.
- DONE:
  - out_valid=1; sum, c_out and over_flow are stable.
  - On an edge with out_ready=1: go to IDLE, out_valid=0.
  - If the latched acc_en=1, the accumulator is loaded with sum on that same edge.
- Latency: out_valid rises NCHUNK cycles after the accept edge. There is no overlap: the next accept is possible at the earliest one cycle after the result handshake.
- Subtract computes a - b - c_in as a + ~b + ~c_in.
  - c_out=1 means no borrow occurred.
  - over_flow uses the same MSB-carry XOR rule as add.
- acc_clr:
  - Acts only in IDLE or DONE.
  - In IDLE with a simultaneous accept: the clear wins, and opA = 0 when acc_en=1.
  - In DONE coinciding with an acc_en result handshake: the clear wins and the accumulator becomes 0.
  - Ignored in CALC.
- Output registers hold their last value in IDLE and CALC; only out_valid qualifies them.
- Input changes while in CALC or DONE have no effect on the operation in flight.
- Reset mid-operation: the operation is aborted with no result handshake, and all reset values are restored on that edge.
- CHUNK=WIDTH: CALC lasts exactly one cycle.

Decomposition:
- Shared package (team arithmetic package) holds:
  - the state enum (IDLE/CALC/DONE);
  - the SEL_ADD/SEL_SUB constants;
  - the NCHUNK derivation function;
  - the index width as $clog2(NCHUNK), minimum 1.
- One natural sub-module, addsub_chunk: a combinational CHUNK-bit adder with carry in, carry out, and carry into its MSB. It is instantiated once and reused each cycle.

Test Plan:
- WIDTH=8, CHUNK=4, add, c_in=0:
  - 0x55+0x44 -> sum 0x99, c_out 0, over_flow 1.
  - 0xBB+0x44 -> 0xFF, 0, 0.
  - 0x11+0x55 -> 0x66, 0, 0.
  - 0xFF+0x55 -> 0x54, 1, 0.
  - out_valid rises exactly 2 cycles after each accept.
- Same operand pairs, sel=1, c_in=0:
  - 0x11 / c 1 / ovf 0.
  - 0x77 / 1 / 1.
  - 0xBC / 0 / 0.
  - 0xAA / 1 / 0.
- WIDTH=32, CHUNK=8, with out_ready held low for 5 cycles after out_valid:
  - 0xFFFFFFFF+0x00000000 with c_in=1 -> 0x00000000, c_out 1.
  - out_valid and sum stay stable while out_ready is low.
  - in_ready stays 0 until one cycle after the result handshake.
- Accumulate, WIDTH=8, CHUNK=1, acc_en=1:
  - Issue acc_clr with the first accept, then b=0x10, 0x20, 0x30 (add).
  - Results 0x10, 0x30, 0x60; each takes 8 cycles to out_valid.
  - Then sub b=0x70 -> 0xF0, c_out 0.
- Reset mid-operation:
  - Assert rst_n=0 for one edge at CALC index 1.
  - Required: out_valid=0, in_ready=1, sum=0, accumulator=0.
  - A new 0x01+0x01 then yields 0x02 normally.
- Mode changes during CALC:
  - Toggling a, b, sel and c_in during CALC has no effect; the result matches the latched operation.
